// File: rtl/ram_rd_check_if.sv
// ram_rd_check_if: single-port RAM read/write port shared by the RAM sequencers
interface ram_rd_check_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rd_data;
  modport master(output ram_en, ram_we, ram_addr, input ram_rd_data);
  modport slave(input ram_en, ram_we, ram_addr, output ram_rd_data);
endinterface

// File: rtl/ram_rd_check.sv
// ram_rd_check: sweeps the RAM with reads, compares against addr+SEED; RD_CHECK_STOP_ON_ERR_EN stops on first mismatch
module ram_rd_check #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1,
  parameter int SEED   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  ram_rd_check_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t            state;
  logic [RD_LAT-1:0] pv;
  logic [ADDR_W-1:0] pt [RD_LAT];
  logic              cv, cm, hit, stop;
  logic [ADDR_W-1:0] ct;
  logic [DATA_W-1:0] exp_d;
  assign bus.ram_we = 1'b0;
  assign exp_d = DATA_W'(pt[RD_LAT-1]) + DATA_W'(SEED);
`ifdef RD_CHECK_STOP_ON_ERR_EN
  assign hit  = cv & cm & ~err_flag;
  assign stop = hit;
`else
  assign hit  = cv & cm;
  assign stop = 1'b0;
`endif
  // track issued reads until their data returns, then register the compare
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pt[i] <= '0;
      cv <= 1'b0;
      cm <= 1'b0;
      ct <= '0;
    end else begin
      pv[0] <= bus.ram_en;
      pt[0] <= bus.ram_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
      end
      cv <= pv[RD_LAT-1];
      cm <= bus.ram_rd_data != exp_d;
      ct <= pt[RD_LAT-1];
    end
  // sweep sequencer and mismatch bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      bus.ram_en     <= 1'b0;
      bus.ram_addr   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_flag       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      if (hit) begin
        err_cnt  <= err_cnt + {{ADDR_W{1'b0}}, ~&err_cnt};
        err_flag <= 1'b1;
        if (!err_flag) first_err_addr <= ct;
      end
      case (state)
        IDLE, DONE:
          if (start) begin
            state          <= ISSUE;
            bus.ram_en     <= 1'b1;
            bus.ram_addr   <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            err_flag       <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
          end
        ISSUE:
          if (bus.ram_addr == LAST || stop) begin
            state      <= DRAIN;
            bus.ram_en <= 1'b0;
          end else bus.ram_addr <= bus.ram_addr + 1'b1;
        default:
          if (~|pv) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
      endcase
    end
endmodule
